// File: rtl/gmii_xmt_if.sv
// Stream-in / GMII-out bundle for the gmii_xmt transmitter.
// master = upstream byte source, slave = the transmitter itself.
interface gmii_xmt_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] gmii_tx_dout;
    logic       busy;
    logic       underrun;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, gmii_tx_en, gmii_tx_er, gmii_tx_dout, busy, underrun
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, gmii_tx_en, gmii_tx_er, gmii_tx_dout, busy, underrun
    );
endinterface

// File: rtl/gmii_xmt.sv
// GMII transmitter: preamble/SFD insertion, underrun abort and inter-frame gap.
// Define GMII_XMT_FCS_EN to compile in short-frame padding and CRC-32 FCS append.
module gmii_xmt #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA_LEN = 60,
    parameter int IFG_LEN      = 12
) (
    input logic       gmii_rx_clk,
    input logic       reset,
    gmii_xmt_if.slave bus
);
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN);
    localparam logic [10:0] IFG_LAST = 11'(IFG_LEN);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] cnt_inc;
    // Stage register holds the byte chosen this cycle; the tx_* register drives the pins.
    logic        stg_en, stg_er, stg_urun;
    logic [7:0]  stg_dout;
    logic        tx_en, tx_er, tx_urun, busy_q;
    logic [7:0]  tx_dout;

    assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

    assign bus.s_ready      = (state == DATA) || (state == DROP);
    assign bus.gmii_tx_en   = tx_en;
    assign bus.gmii_tx_er   = tx_er;
    assign bus.gmii_tx_dout = tx_dout;
    assign bus.busy         = busy_q;
    assign bus.underrun     = tx_urun;

`ifdef GMII_XMT_FCS_EN
    localparam logic [10:0] MIN_LAST = 11'(MIN_DATA_LEN);

    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        crc_nxt  = crc_byte(crc_q, (state == PAD) ? 8'h00 : bus.s_data);
        fcs_byte = ~crc_q[7:0];
        case (cnt[1:0])
            2'd1:    fcs_byte = ~crc_q[15:8];
            2'd2:    fcs_byte = ~crc_q[23:16];
            2'd3:    fcs_byte = ~crc_q[31:24];
            default: fcs_byte = ~crc_q[7:0];
        endcase
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge gmii_rx_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            stg_en   <= 1'b0;
            stg_er   <= 1'b0;
            stg_urun <= 1'b0;
            stg_dout <= 8'h00;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;
            tx_urun  <= 1'b0;
            tx_dout  <= 8'h00;
            busy_q   <= 1'b0;
`ifdef GMII_XMT_FCS_EN
            crc_q    <= '1;
`endif
        end else begin
            tx_en    <= stg_en;
            tx_er    <= stg_er;
            tx_urun  <= stg_urun;
            tx_dout  <= stg_dout;
            stg_en   <= 1'b0;
            stg_er   <= 1'b0;
            stg_urun <= 1'b0;
            stg_dout <= 8'h00;

            case (state)
                // IDLE already stages the first preamble byte so it reaches the pins one edge later.
                IDLE: begin
                    cnt <= 11'd1;
`ifdef GMII_XMT_FCS_EN
                    crc_q <= '1;
`endif
                    if (bus.s_valid) begin
                        stg_en   <= 1'b1;
                        stg_dout <= 8'h55;
                        busy_q   <= 1'b1;
                        state    <= (PRE_LAST > 11'd1) ? PRE : SFD;
                    end
                end
                PRE: begin
                    stg_en   <= 1'b1;
                    stg_dout <= 8'h55;
                    cnt      <= cnt_inc;
                    if (cnt_inc == PRE_LAST) state <= SFD;
                end
                SFD: begin
                    stg_en   <= 1'b1;
                    stg_dout <= 8'hD5;
                    cnt      <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    stg_en <= 1'b1;
                    if (bus.s_valid) begin
                        stg_dout <= bus.s_data;
                        cnt      <= cnt_inc;
`ifdef GMII_XMT_FCS_EN
                        crc_q    <= crc_nxt;
                        if (bus.s_last) begin
                            if (cnt_inc < MIN_LAST) begin
                                state <= PAD;
                            end else begin
                                state <= FCS;
                                cnt   <= '0;
                            end
                        end
`else
                        if (bus.s_last) begin
                            state <= IFG;
                            cnt   <= '0;
                        end
`endif
                    end else begin
                        stg_er   <= 1'b1;
                        stg_urun <= 1'b1;
                        state    <= DROP;
                    end
                end
`ifdef GMII_XMT_FCS_EN
                PAD: begin
                    stg_en <= 1'b1;
                    crc_q  <= crc_nxt;
                    cnt    <= cnt_inc;
                    if (cnt_inc >= MIN_LAST) begin
                        state <= FCS;
                        cnt   <= '0;
                    end
                end
                FCS: begin
                    stg_en   <= 1'b1;
                    stg_dout <= fcs_byte;
                    cnt      <= cnt_inc;
                    if (cnt[1:0] == 2'd3) begin
                        state <= IFG;
                        cnt   <= '0;
                    end
                end
`endif
                DROP: begin
                    if (bus.s_valid && bus.s_last) begin
                        state <= IFG;
                        cnt   <= '0;
                    end
                end
                // One cycle longer than IFG_LEN: it stands in for the IDLE cycle that
                // overlaps the first preamble byte, keeping the pin-level gap at IFG_LEN + 1.
                IFG: begin
                    cnt <= cnt_inc;
                    if (cnt == IFG_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_xmt.sv
// Scoreboard bench for gmii_xmt: stimulus queues expected GMII beats, a negedge
// monitor pops and compares them and checks burst lengths, gaps and FCS residue.
module tb_gmii_xmt;
    localparam int PRE_N = 7;
    localparam int MIN_N = 60;
    localparam int IFG_N = 12;

    typedef struct packed {
        logic       er;
        logic       urun;
        logic [7:0] d;
    } beat_t;

    logic clk;
    logic reset;
    gmii_xmt_if bus();

    gmii_xmt dut (
        .gmii_rx_clk (clk),
        .reset       (reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_rise_cyc = 0;
    int last_gap = 0;
    int urun_cnt = 0;

    beat_t      exp_q[$];
    int         len_q[$];
    logic [7:0] fr[128];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++)
            r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push(input logic er, input logic urun, input logic [7:0] d);
        beat_t b;
        b.er = er;
        b.urun = urun;
        b.d = d;
        exp_q.push_back(b);
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fr[i] = base + 8'(i);
    endtask

    // Queue the beats of one frame; abort_at > 0 ends it with the error byte.
    task automatic expect_frame(input int n, input int abort_at);
        int ndat;
        ndat = (abort_at > 0) ? abort_at : n;
        for (int i = 0; i < PRE_N; i++) push(1'b0, 1'b0, 8'h55);
        push(1'b0, 1'b0, 8'hD5);
        for (int i = 0; i < ndat; i++) push(1'b0, 1'b0, fr[i]);
        if (abort_at > 0) begin
            push(1'b1, 1'b1, 8'h00);
            len_q.push_back(PRE_N + 1 + abort_at + 1);
        end else begin
`ifdef GMII_XMT_FCS_EN
            logic [31:0] crc;
            int          total;
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < n; i++) crc = crc8(crc, fr[i]);
            for (int i = n; i < MIN_N; i++) begin
                push(1'b0, 1'b0, 8'h00);
                crc = crc8(crc, 8'h00);
            end
            crc = ~crc;
            push(1'b0, 1'b0, crc[7:0]);
            push(1'b0, 1'b0, crc[15:8]);
            push(1'b0, 1'b0, crc[23:16]);
            push(1'b0, 1'b0, crc[31:24]);
            total = (n < MIN_N) ? MIN_N : n;
            len_q.push_back(PRE_N + 1 + total + 4);
`else
            len_q.push_back(PRE_N + 1 + n);
`endif
        end
    endtask

    // Drive fr[0..n-1]; drop s_valid for one cycle after drop_at bytes;
    // return with s_valid still high after stop_at bytes.
    task automatic send(input int n, input int drop_at, input int stop_at);
        int i;
        int budget;
        i = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = fr[0];
        bus.s_last  = (n == 1);
        while (i < n) begin
            budget = 0;
            @(negedge clk);
            while (!bus.s_ready) begin
                budget++;
                if (budget > 1000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL s_ready_timeout: got no ready after %0d cycles, want ready", budget);
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            i++;
            last_acc_cyc = cyc;
            if (i == stop_at) return;
            if (i == drop_at) begin
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
                bus.s_valid = 1'b1;
            end
            if (i < n) begin
                bus.s_data = fr[i];
                bus.s_last = (i == n - 1);
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || bus.busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_and_idle", 32'(t < 3000), 32'd1);
    endtask

    // Monitor: compares every tx_en beat and checks each burst at its falling edge.
    logic        prev_en = 1'b0;
    logic        seen = 1'b0;
    logic        run_er = 1'b0;
    int          run_len = 0;
    int          low_cnt = 0;
    logic [31:0] res = 32'hFFFFFFFF;

    always @(negedge clk) begin
        beat_t act;
        beat_t b;
        int    want;
        if (reset) begin
            prev_en = 1'b0;
            run_len = 0;
            low_cnt = 0;
        end else begin
            if (bus.underrun) urun_cnt++;
            if (bus.gmii_tx_en) begin
                if (!prev_en) begin
                    if (seen) last_gap = low_cnt;
                    last_rise_cyc = cyc;
                    seen    = 1'b1;
                    run_len = 0;
                    run_er  = 1'b0;
                    res     = 32'hFFFFFFFF;
                end
                run_len++;
                if (bus.gmii_tx_er) run_er = 1'b1;
                if (run_len > PRE_N + 1) res = crc8(res, bus.gmii_tx_dout);
                act.er   = bus.gmii_tx_er;
                act.urun = bus.underrun;
                act.d    = bus.gmii_tx_dout;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h, want no beat", act);
                end else begin
                    b = exp_q.pop_front();
                    check("beat", 32'(act), 32'(b));
                end
                low_cnt = 0;
            end else begin
                if (prev_en) begin
                    if (len_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_burst: got length %0d, want none", run_len);
                    end else begin
                        want = len_q.pop_front();
                        check("tx_en_length", 32'(run_len), 32'(want));
                    end
`ifdef GMII_XMT_FCS_EN
                    if (!run_er) check("fcs_residue", res, 32'hDEBB20E3);
`endif
                end
                low_cnt++;
            end
            prev_en = bus.gmii_tx_en;
        end
    end

    initial begin
        int u0;
        int acc;
        reset       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_en",    32'(bus.gmii_tx_en),   32'd0);
        check("rst_tx_er",    32'(bus.gmii_tx_er),   32'd0);
        check("rst_dout",     32'(bus.gmii_tx_dout), 32'h00);
        check("rst_busy",     32'(bus.busy),         32'd0);
        check("rst_underrun", 32'(bus.underrun),     32'd0);
        check("rst_s_ready",  32'(bus.s_ready),      32'd0);
        bus.s_valid = 1'b0;
        reset       = 1'b0;
        repeat (2) @(negedge clk);

        // 64-byte frame 0x00..0x3F
        fill(8'h00, 64);
        expect_frame(64, 0);
        send(64, 0, 0);
        wait_idle();

        // 1-byte frame 0xAB
        fr[0] = 8'hAB;
        expect_frame(1, 0);
        send(1, 0, 0);
        wait_idle();

        // two 64-byte frames back to back, s_valid never dropped in between
        fill(8'h10, 64);
        expect_frame(64, 0);
        send(64, 0, 0);
        fill(8'h80, 64);
        expect_frame(64, 0);
        send(64, 0, 0);
        wait_idle();
        check("b2b_gap", 32'(last_gap), 32'(IFG_N + 1));

        // 100-byte frame with s_valid dropped after byte 20, then a normal frame
        u0 = urun_cnt;
        fill(8'h20, 100);
        expect_frame(100, 20);
        send(100, 20, 0);
        acc = last_acc_cyc;
        fill(8'hC0, 64);
        expect_frame(64, 0);
        send(64, 0, 0);
        wait_idle();
        check("underrun_pulses", 32'(urun_cnt - u0), 32'd1);
        check("restart_after_ifg", 32'((last_rise_cyc - acc) > IFG_N), 32'd1);

        // reset while the 30th data byte is on the bus
        fill(8'h40, 64);
        expect_frame(64, 0);
        send(64, 0, 31);
        check("busy_mid_frame", 32'(bus.busy), 32'd1);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        exp_q.delete();
        len_q.delete();
        #1;
        check("midrst_tx_en", 32'(bus.gmii_tx_en),   32'd0);
        check("midrst_dout",  32'(bus.gmii_tx_dout), 32'h00);
        check("midrst_tx_er", 32'(bus.gmii_tx_er),   32'd0);
        check("midrst_busy",  32'(bus.busy),         32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 10-byte frame after reset: full preamble, verbatim or padded per build
        fill(8'h90, 10);
        expect_frame(10, 0);
        send(10, 0, 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
